// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : can_pkg
//  Description : Shared definitions for the CAN bit timing logic.
//                - seg_e : segment encoding (SYNC, PROP, PHASE1, PHASE2)
//                - CAN_SEG_W : default width of the segment length fields
//                - CAN_RECESSIVE : idle / reset level of the CAN bus
//  Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

    localparam int CAN_SEG_W = 3;

    typedef enum logic [1:0] {
        SEG_SYNC   = 2'd0,
        SEG_PROP   = 2'd1,
        SEG_PHASE1 = 2'd2,
        SEG_PHASE2 = 2'd3
    } seg_e;

    localparam logic CAN_RECESSIVE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/can_tq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : can_tq_gen
//  Description : Time-quantum generator. Counts clk cycles 0..brp_eff-1 and
//                pulses tq_tick_o on the last clk of every quantum.
//                brp_eff = max(brp_i, 1).
//  Ports       : clk_i      system clock
//                rst_i      asynchronous reset, active high
//                run_i      0 holds the counter at zero with no ticks
//                clr_i      synchronous restart of the current quantum
//                brp_i      clocks per quantum (0 behaves as 1)
//                tq_tick_o  last clk of a quantum
//  Revision    : 1.0 - initial release
// ============================================================================
module can_tq_gen #(
    parameter int BRP_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [BRP_W-1:0] brp_i,
    output logic             tq_tick_o
);

    logic [BRP_W-1:0] presc_q;
    logic [BRP_W-1:0] presc_d;
    logic [BRP_W-1:0] w_last;

    // brp of 0 collapses to a one-clock quantum, same as brp of 1
    assign w_last    = (brp_i == '0) ? '0 : brp_i - BRP_W'(1);
    assign tq_tick_o = run_i && (presc_q == w_last);

    always_comb begin
        presc_d = presc_q;
        if (!run_i || clr_i) begin
            presc_d = '0;
        end else if (tq_tick_o) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + BRP_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_bit_timing.sv
`default_nettype none
// ============================================================================
//  Module      : can_bit_timing
//  Description : CAN bit timing logic. Splits every bit into SYNC / PROP /
//                PHASE1 / PHASE2 time quanta, performs hard sync and
//                SJW-limited resynchronisation on recessive->dominant edges
//                and produces the sample point and bit-start strobes.
//  Ports       : clk_i           system clock
//                rst_i           asynchronous reset, active high
//                enable_i        0: idle + config capture, 1: run
//                brp_i           clocks per tq (0 treated as 1)
//                prop_seg_i      PROP length-1
//                phase_seg1_i    PHASE1 length-1
//                phase_seg2_i    PHASE2 length-1 (0 forced to 1)
//                sjw_i           resync jump width-1
//                hard_sync_en_i  next falling edge performs a hard sync
//                rx_i            synchronised CAN rx
//                tq_tick_o       last clk of every tq
//                bit_start_o     first clk of SYNC
//                sample_pulse_o  clk after the sampling edge
//                sampled_bit_o   rx captured at the sample point
//                seg_o           current segment
//                hard_sync_o     a hard sync was taken
//  Revision    : 1.0 - initial release
// ============================================================================
module can_bit_timing
    import can_pkg::*;
#(
    parameter int BRP_W = 16,
    parameter int SEG_W = CAN_SEG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [BRP_W-1:0] brp_i,
    input  logic [SEG_W-1:0] prop_seg_i,
    input  logic [SEG_W-1:0] phase_seg1_i,
    input  logic [SEG_W-1:0] phase_seg2_i,
    input  logic [1:0]       sjw_i,
    input  logic             hard_sync_en_i,
    input  logic             rx_i,
    output logic             tq_tick_o,
    output logic             bit_start_o,
    output logic             sample_pulse_o,
    output logic             sampled_bit_o,
    output logic [1:0]       seg_o,
    output logic             hard_sync_o
);

    // Wide enough for PROP + lengthened PHASE1 elapsed counts
    localparam int CNT_W = SEG_W + 3;

    // Shadowed configuration, frozen while running
    logic [BRP_W-1:0] brp_q;
    logic [SEG_W-1:0] prop_q;
    logic [SEG_W-1:0] ph1_q;
    logic [SEG_W-1:0] ph2_q;
    logic [1:0]       sjw_q;
    logic             en_q;
    logic             rx_d_q;

    seg_e             seg_q,          seg_d;
    logic [CNT_W-1:0] tq_cnt_q,       tq_cnt_d;
    logic [CNT_W-1:0] ext_q,          ext_d;
    logic [CNT_W-1:0] shrink_q,       shrink_d;
    logic             sync_done_q,    sync_done_d;
    logic             sampled_bit_q,  sampled_bit_d;
    logic             sample_pulse_q, sample_pulse_d;
    logic             bit_start_q,    bit_start_d;
    logic             hard_sync_q,    hard_sync_d;

    logic             w_tick;
    logic [CNT_W-1:0] w_prop_len;
    logic [CNT_W-1:0] w_ph1_len;
    logic [CNT_W-1:0] w_ph2_base;
    logic [CNT_W-1:0] w_ph2_len;
    logic [CNT_W-1:0] w_ph2_len_n;
    logic [CNT_W-1:0] w_shrink_n;
    logic [CNT_W-1:0] w_sjw_raw;
    logic [CNT_W-1:0] w_sjw_eff;
    logic [CNT_W-1:0] w_e_early;
    logic [CNT_W-1:0] w_e_late;
    logic             w_edge;
    logic             w_hs;
    logic             w_rs;
    logic             w_rs_early;
    logic             w_rs_late;
    logic             w_restart;

    can_tq_gen #(
        .BRP_W     (BRP_W)
    ) u_tq_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (en_q),
        .clr_i     (w_restart),
        .brp_i     (brp_q),
        .tq_tick_o (w_tick)
    );

    // Segment lengths in tq
    assign w_prop_len  = CNT_W'(prop_q) + CNT_W'(1);
    assign w_ph1_len   = CNT_W'(ph1_q) + CNT_W'(1) + ext_q;
    assign w_ph2_base  = (ph2_q == '0) ? CNT_W'(2) : CNT_W'(ph2_q) + CNT_W'(1);
    assign w_ph2_len   = w_ph2_base - shrink_q;
    assign w_sjw_raw   = CNT_W'(sjw_q) + CNT_W'(1);
    assign w_sjw_eff   = (w_sjw_raw < w_ph2_base) ? w_sjw_raw : w_ph2_base;

    // Edge classification
    assign w_edge      = en_q && rx_d_q && !rx_i;
    assign w_hs        = w_edge && hard_sync_en_i;
    assign w_rs        = w_edge && !hard_sync_en_i && !sync_done_q && sampled_bit_q;
    assign w_rs_early  = w_rs && ((seg_q == SEG_PROP) || (seg_q == SEG_PHASE1));
    assign w_rs_late   = w_rs && (seg_q == SEG_PHASE2);

    // Phase error: tq elapsed since SYNC ended, or tq left in PHASE2
    assign w_e_early   = (seg_q == SEG_PROP) ? tq_cnt_q + CNT_W'(1)
                                             : w_prop_len + tq_cnt_q + CNT_W'(1);
    assign w_e_late    = w_ph2_len - tq_cnt_q;

    // A late edge within one SJW of the bit end restarts the bit like a hard sync
    assign w_restart   = w_hs || (w_rs_late && (w_e_late <= w_sjw_eff));

    // Shortening is applied immediately so a coincident tick can end PHASE2 now
    assign w_shrink_n  = (w_rs_late && !w_restart) ? w_sjw_eff : shrink_q;
    assign w_ph2_len_n = w_ph2_base - w_shrink_n;

    always_comb begin
        seg_d          = seg_q;
        tq_cnt_d       = tq_cnt_q;
        ext_d          = ext_q;
        shrink_d       = w_shrink_n;
        sync_done_d    = sync_done_q;
        sampled_bit_d  = sampled_bit_q;
        sample_pulse_d = 1'b0;
        bit_start_d    = 1'b0;
        hard_sync_d    = 1'b0;

        // Segment advance uses pre-edge lengths (except immediate shortening)
        if (w_tick) begin
            case (seg_q)
                SEG_SYNC: begin
                    seg_d    = SEG_PROP;
                    tq_cnt_d = '0;
                end
                SEG_PROP: begin
                    if (tq_cnt_q >= w_prop_len - CNT_W'(1)) begin
                        seg_d    = SEG_PHASE1;
                        tq_cnt_d = '0;
                    end else begin
                        tq_cnt_d = tq_cnt_q + CNT_W'(1);
                    end
                end
                SEG_PHASE1: begin
                    if (tq_cnt_q >= w_ph1_len - CNT_W'(1)) begin
                        seg_d          = SEG_PHASE2;
                        tq_cnt_d       = '0;
                        sample_pulse_d = 1'b1;
                        sampled_bit_d  = rx_i;
                    end else begin
                        tq_cnt_d = tq_cnt_q + CNT_W'(1);
                    end
                end
                SEG_PHASE2: begin
                    if (tq_cnt_q >= w_ph2_len_n - CNT_W'(1)) begin
                        seg_d       = SEG_SYNC;
                        tq_cnt_d    = '0;
                        ext_d       = '0;
                        shrink_d    = '0;
                        bit_start_d = 1'b1;
                    end else begin
                        tq_cnt_d = tq_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    seg_d    = SEG_SYNC;
                    tq_cnt_d = '0;
                end
            endcase
        end

        if (sample_pulse_d) begin
            sync_done_d = 1'b0;
        end

        // Sync actions override the plain advance
        if (w_restart) begin
            seg_d       = SEG_SYNC;
            tq_cnt_d    = '0;
            ext_d       = '0;
            shrink_d    = '0;
            bit_start_d = 1'b1;
            hard_sync_d = w_hs;
            sync_done_d = 1'b1;
        end else if (w_rs_early) begin
            ext_d       = (w_e_early < w_sjw_eff) ? w_e_early : w_sjw_eff;
            sync_done_d = 1'b1;
        end else if (w_rs_late) begin
            sync_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            brp_q          <= '0;
            prop_q         <= '0;
            ph1_q          <= '0;
            ph2_q          <= '0;
            sjw_q          <= '0;
            en_q           <= 1'b0;
            rx_d_q         <= CAN_RECESSIVE;
            seg_q          <= SEG_SYNC;
            tq_cnt_q       <= '0;
            ext_q          <= '0;
            shrink_q       <= '0;
            sync_done_q    <= 1'b0;
            sampled_bit_q  <= CAN_RECESSIVE;
            sample_pulse_q <= 1'b0;
            bit_start_q    <= 1'b0;
            hard_sync_q    <= 1'b0;
        end else begin
            en_q   <= enable_i;
            rx_d_q <= rx_i;
            if (!enable_i) begin
                brp_q          <= brp_i;
                prop_q         <= prop_seg_i;
                ph1_q          <= phase_seg1_i;
                ph2_q          <= phase_seg2_i;
                sjw_q          <= sjw_i;
                seg_q          <= SEG_SYNC;
                tq_cnt_q       <= '0;
                ext_q          <= '0;
                shrink_q       <= '0;
                sync_done_q    <= 1'b0;
                sampled_bit_q  <= CAN_RECESSIVE;
                sample_pulse_q <= 1'b0;
                bit_start_q    <= 1'b0;
                hard_sync_q    <= 1'b0;
            end else begin
                seg_q          <= seg_d;
                tq_cnt_q       <= tq_cnt_d;
                ext_q          <= ext_d;
                shrink_q       <= shrink_d;
                sync_done_q    <= sync_done_d;
                sampled_bit_q  <= sampled_bit_d;
                sample_pulse_q <= sample_pulse_d;
                bit_start_q    <= bit_start_d;
                hard_sync_q    <= hard_sync_d;
            end
        end
    end

    assign tq_tick_o      = w_tick;
    assign bit_start_o    = bit_start_q;
    assign sample_pulse_o = sample_pulse_q;
    assign sampled_bit_o  = sampled_bit_q;
    assign seg_o          = seg_q;
    assign hard_sync_o    = hard_sync_q;

endmodule
`default_nettype wire

// File: tb/tb_can_bit_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_bit_timing
//  Description : Directed self-checking bench for can_bit_timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_bit_timing;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [15:0] brp_i;
    logic [2:0]  prop_seg_i;
    logic [2:0]  phase_seg1_i;
    logic [2:0]  phase_seg2_i;
    logic [1:0]  sjw_i;
    logic        hard_sync_en_i;
    logic        rx_i;
    logic        tq_tick_o;
    logic        bit_start_o;
    logic        sample_pulse_o;
    logic        sampled_bit_o;
    logic [1:0]  seg_o;
    logic        hard_sync_o;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    can_bit_timing #(
        .BRP_W          (16),
        .SEG_W          (3)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .brp_i          (brp_i),
        .prop_seg_i     (prop_seg_i),
        .phase_seg1_i   (phase_seg1_i),
        .phase_seg2_i   (phase_seg2_i),
        .sjw_i          (sjw_i),
        .hard_sync_en_i (hard_sync_en_i),
        .rx_i           (rx_i),
        .tq_tick_o      (tq_tick_o),
        .bit_start_o    (bit_start_o),
        .sample_pulse_o (sample_pulse_o),
        .sampled_bit_o  (sampled_bit_o),
        .seg_o          (seg_o),
        .hard_sync_o    (hard_sync_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // kind: 0 bit_start, 1 sample_pulse, 2 tq_tick
    task automatic wait_ev(input string tag, input int kind, output int t);
        bit got;
        got = 1'b0;
        t   = -1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if ((kind == 0 && bit_start_o) || (kind == 1 && sample_pulse_o) ||
                (kind == 2 && tq_tick_o)) begin
                got = 1'b1;
                t   = cyc;
                break;
            end
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL %s: observed=timeout expected=event", tag);
        end
    endtask

    task automatic restart_run();
        enable_i       = 1'b0;
        rx_i           = 1'b1;
        hard_sync_en_i = 1'b0;
        step(2);
        enable_i = 1'b1;
        step(1);
    endtask

    initial begin
        int t0, t1, t2, t3, ta, tb;

        rst_i          = 1'b1;
        enable_i       = 1'b0;
        rx_i           = 1'b1;
        hard_sync_en_i = 1'b0;
        brp_i          = 16'd4;
        prop_seg_i     = 3'd1;
        phase_seg1_i   = 3'd2;
        phase_seg2_i   = 3'd2;
        sjw_i          = 2'd0;
        step(3);
        chk("rst_seg",          32'(seg_o),          0);
        chk("rst_bit_start",    32'(bit_start_o),    0);
        chk("rst_sample_pulse", 32'(sample_pulse_o), 0);
        chk("rst_sampled_bit",  32'(sampled_bit_o),  1);
        chk("rst_tq_tick",      32'(tq_tick_o),      0);
        chk("rst_hard_sync",    32'(hard_sync_o),    0);

        rst_i = 1'b0;
        step(2);
        enable_i = 1'b1;
        step(1);

        // Nominal timing: brp=4, 1+2+3+3 tq
        wait_ev("bs0", 0, t0);
        chk("bs_seg_sync", 32'(seg_o), 0);
        wait_ev("sp0", 1, t1);
        chk("sample_offset", 32'(t1 - t0), 24);
        chk("sp_seg_phase2", 32'(seg_o), 3);
        chk("sp_value", 32'(sampled_bit_o), 1);
        wait_ev("bs1", 0, t2);
        chk("bit_len", 32'(t2 - t0), 36);
        wait_ev("tick_a", 2, ta);
        wait_ev("tick_b", 2, tb);
        chk("tq_period", 32'(tb - ta), 4);
        wait_ev("bs2", 0, t3);
        chk("bit_len2", 32'(t3 - t2), 36);

        // Falling edge during SYNC: no resync, dominant gets sampled
        rx_i = 1'b0;
        wait_ev("sp_low", 1, t1);
        chk("sync_edge_no_action", 32'(t1 - t3), 24);
        chk("sampled_low", 32'(sampled_bit_o), 0);

        // Asynchronous reset in the middle of PHASE2
        step(2);
        chk("pre_rst_seg", 32'(seg_o), 3);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_seg",         32'(seg_o),         0);
        chk("midrst_sampled_bit", 32'(sampled_bit_o), 1);
        chk("midrst_tq_tick",     32'(tq_tick_o),     0);
        step(1);
        chk("midrst_hold_seg", 32'(seg_o), 0);
        rst_i = 1'b0;
        rx_i  = 1'b1;

        // brp=0 behaves like brp=1: one clk per tq
        brp_i = 16'd0;
        restart_run();
        chk("en_seg_sync", 32'(seg_o), 0);
        wait_ev("b0_bs_a", 0, t0);
        wait_ev("b0_sp",   1, t1);
        chk("brp0_sample", 32'(t1 - t0), 6);
        wait_ev("b0_bs_b", 0, t2);
        chk("brp0_bit", 32'(t2 - t0), 9);
        chk("brp0_tick_a", 32'(tq_tick_o), 1);
        step(1);
        chk("brp0_tick_b", 32'(tq_tick_o), 1);

        brp_i = 16'd1;
        restart_run();
        wait_ev("b1_bs_a", 0, t0);
        wait_ev("b1_sp",   1, t1);
        chk("brp1_sample", 32'(t1 - t0), 6);
        wait_ev("b1_bs_b", 0, t2);
        chk("brp1_bit", 32'(t2 - t0), 9);

        // Config change while running is ignored
        brp_i = 16'd4;
        wait_ev("frz_bs", 0, t3);
        chk("frozen_bit", 32'(t3 - t2), 9);

        // Hard sync in the middle of PHASE1
        restart_run();
        wait_ev("hs_bs", 0, t0);
        step(16);
        chk("hs_pre_seg", 32'(seg_o), 2);
        hard_sync_en_i = 1'b1;
        rx_i           = 1'b0;
        step(1);
        t1 = cyc;
        chk("hs_seg",       32'(seg_o),       0);
        chk("hs_pulse",     32'(hard_sync_o), 1);
        chk("hs_bit_start", 32'(bit_start_o), 1);
        hard_sync_en_i = 1'b0;
        step(1);
        chk("hs_pulse_end", 32'(hard_sync_o), 0);
        wait_ev("hs_next", 0, t2);
        chk("hs_next_bit", 32'(t2 - t1), 36);

        // Resync in PROP tq2, sjw 1 tq: PHASE1 +1 tq
        restart_run();
        wait_ev("rp_bs", 0, t0);
        step(9);
        chk("rp_pre_seg", 32'(seg_o), 1);
        rx_i = 1'b0;
        wait_ev("rp_sp", 1, t1);
        chk("rs_prop_sample", 32'(t1 - t0), 28);
        wait_ev("rp_bs2", 0, t2);
        chk("rs_prop_bit", 32'(t2 - t0), 40);
        wait_ev("rp_bs3", 0, t3);
        chk("rs_restored", 32'(t3 - t2), 36);

        // Same edge with sjw=4 tq, clamped by PHASE2 (3) and by e (2)
        sjw_i = 2'd3;
        restart_run();
        wait_ev("rj_bs", 0, t0);
        step(9);
        rx_i = 1'b0;
        wait_ev("rj_sp", 1, t1);
        chk("rs_sjw3_sample", 32'(t1 - t0), 32);

        // PHASE2 edge with 3 tq left: shorten by 1 tq, second edge ignored
        sjw_i = 2'd0;
        restart_run();
        wait_ev("sh_bs", 0, t0);
        wait_ev("sh_sp", 1, t1);
        step(1);
        rx_i = 1'b0;
        step(1);
        rx_i = 1'b1;
        step(3);
        rx_i = 1'b0;
        wait_ev("sh_bs2", 0, t2);
        chk("shorten_bit", 32'(t2 - t0), 32);
        chk("shorten_no_hs", 32'(hard_sync_o), 0);

        // PHASE2 edge with 1 tq left: behaves as hard sync without hard_sync pulse
        restart_run();
        wait_ev("ls_bs", 0, t0);
        wait_ev("ls_sp", 1, t1);
        step(9);
        chk("ls_pre_seg", 32'(seg_o), 3);
        rx_i = 1'b0;
        step(1);
        chk("late_restart_bs",  32'(bit_start_o), 1);
        chk("late_restart_seg", 32'(seg_o),       0);
        chk("late_restart_hs",  32'(hard_sync_o), 0);
        chk("late_restart_len", 32'(cyc - t0),    34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
